// File: rtl/chkmon_pkg.sv
// Shared types for the checkpoint sequence monitor.
// Holds the FSM state encoding and the MODE selector values.
package chkmon_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARMED,
        ST_PASS,
        ST_FAIL
    } state_e;

    localparam int MODE_INORDER = 0;
    localparam int MODE_STRICT  = 1;

endpackage

// File: rtl/checkpoint_seq_monitor_if.sv
// Configuration/control bundle for checkpoint_seq_monitor.
// master: drives expected-entry writes, length, start and abort.
// slave : the monitor, which samples them.
interface checkpoint_seq_monitor_if #(
    parameter int DATA_W = 16,
    parameter int AW     = 3
);
    logic              cfg_we_i;
    logic [AW-1:0]     cfg_addr_i;
    logic [DATA_W-1:0] cfg_data_i;
    logic [AW:0]       cfg_len_i;
    logic              start_i;
    logic              abort_i;

    modport master (
        output cfg_we_i, cfg_addr_i, cfg_data_i,
        output cfg_len_i, start_i, abort_i
    );

    modport slave (
        input cfg_we_i, cfg_addr_i, cfg_data_i,
        input cfg_len_i, start_i, abort_i
    );
endinterface

// File: rtl/chk_stabilizer.sv
// Captures the checkpoint bus and qualifies values that stay stable.
// In: clk_i, rst_i, chk_i. Out: chk_o (qualified value), fresh_o (one pulse per qualification).
module chk_stabilizer #(
    parameter int DATA_W     = 16,
    parameter int STABLE_CYC = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [DATA_W-1:0] chk_i,
    output logic [DATA_W-1:0] chk_o,
    output logic              fresh_o
);
    localparam int CW = 8;
    localparam logic [CW-1:0] STAB_MAX = CW'(STABLE_CYC);

    logic [DATA_W-1:0] chk_q;
    logic [DATA_W-1:0] val_q;
    logic [CW-1:0]     stab_q, stab_d;
    logic              used_q, used_d;
    logic              fresh_q;
    logic              changed;
    logic              qual;

    assign changed = (chk_i != chk_q);
    assign qual    = (stab_q == STAB_MAX);

    always_comb begin
        stab_d = stab_q;
        if (changed) begin
            stab_d = '0;
        end else if (!qual) begin
            stab_d = stab_q + 1'b1;
        end
    end

    // A qualified value fires once; the bus must change to re-arm.
    assign used_d = changed ? 1'b0 : (used_q | qual);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            chk_q   <= '0;
            val_q   <= '0;
            stab_q  <= '0;
            used_q  <= 1'b0;
            fresh_q <= 1'b0;
        end else begin
            chk_q   <= chk_i;
            stab_q  <= stab_d;
            used_q  <= used_d;
            fresh_q <= qual & ~used_q;
            val_q   <= chk_q;
        end
    end

    assign chk_o   = val_q;
    assign fresh_o = fresh_q;
endmodule

// File: rtl/checkpoint_seq_monitor.sv
// Checks firmware checkpoint codes against a programmed ordered list.
// Ports: wb_clk_i/wb_rst_i, chk_i bus, cfg (slave bundle), status busy/pass/fail/timeout/step/hit/hit_val.
module checkpoint_seq_monitor
    import chkmon_pkg::*;
#(
    parameter  int DATA_W     = 16,
    parameter  int DEPTH      = 8,
    parameter  int STABLE_CYC = 2,
    parameter  int TIMEOUT    = 250000,
    parameter  int TO_W       = 32,
    parameter  int MODE       = 0,
    localparam int AW         = $clog2(DEPTH)
) (
    input  logic                    wb_clk_i,
    input  logic                    wb_rst_i,
    input  logic [DATA_W-1:0]       chk_i,
    checkpoint_seq_monitor_if.slave cfg,
    output logic                    busy_o,
    output logic                    pass_o,
    output logic                    fail_o,
    output logic                    timeout_o,
    output logic [AW:0]             step_o,
    output logic                    hit_o,
    output logic [DATA_W-1:0]       hit_val_o
);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);
    localparam logic [AW:0]     DEPTH_L = (AW+1)'(DEPTH);
    localparam bit              STRICT  = (MODE == MODE_STRICT);
    localparam bit              TO_EN   = (TIMEOUT != 0);

    state_e            state_q, state_d;
    logic [DATA_W-1:0] exp_q [DEPTH];
    logic [AW:0]       len_q, len_d;
    logic [AW:0]       step_q, step_d;
    logic [TO_W-1:0]   tcnt_q, tcnt_d;
    logic              to_q, to_d;
    logic              hit_q, hit_d;
    logic [DATA_W-1:0] hv_q, hv_d;

    logic [DATA_W-1:0] cur;
    logic              fresh;
    logic [DATA_W-1:0] exp_cur;
    logic              len_bad;
    logic              match;
    logic              stray;
    logic              to_hit;

    chk_stabilizer #(
        .DATA_W     (DATA_W),
        .STABLE_CYC (STABLE_CYC)
    ) u_stab (
        .clk_i   (wb_clk_i),
        .rst_i   (wb_rst_i),
        .chk_i   (chk_i),
        .chk_o   (cur),
        .fresh_o (fresh)
    );

    assign exp_cur = exp_q[step_q[AW-1:0]];
    assign len_bad = (cfg.cfg_len_i == '0) || (cfg.cfg_len_i > DEPTH_L);
    assign match   = fresh && (cur == exp_cur);
    // The value that just hit may legitimately reappear in strict mode.
    assign stray   = STRICT && fresh && (cur != exp_cur)
                     && ((step_q == '0) || (cur != hv_q));
    assign to_hit  = TO_EN && (tcnt_q == TO_LAST);

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        step_d  = step_q;
        tcnt_d  = tcnt_q;
        to_d    = to_q;
        hit_d   = 1'b0;
        hv_d    = hv_q;
        unique case (state_q)
            ST_ARMED: begin
                if (cfg.abort_i) begin
                    state_d = ST_IDLE;
                end else if (match) begin
                    hit_d  = 1'b1;
                    hv_d   = cur;
                    step_d = step_q + 1'b1;
                    tcnt_d = '0;
                    if (step_q + 1'b1 == len_q) begin
                        state_d = ST_PASS;
                    end
                end else if (stray) begin
                    state_d = ST_FAIL;
                end else if (to_hit) begin
                    state_d = ST_FAIL;
                    to_d    = 1'b1;
                end else begin
                    tcnt_d = tcnt_q + 1'b1;
                end
            end
            default: begin
                if (cfg.start_i) begin
                    to_d    = 1'b0;
                    step_d  = '0;
                    tcnt_d  = '0;
                    len_d   = cfg.cfg_len_i;
                    state_d = len_bad ? ST_FAIL : ST_ARMED;
                end
            end
        endcase
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q <= ST_IDLE;
            len_q   <= '0;
            step_q  <= '0;
            tcnt_q  <= '0;
            to_q    <= 1'b0;
            hit_q   <= 1'b0;
            hv_q    <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            step_q  <= step_d;
            tcnt_q  <= tcnt_d;
            to_q    <= to_d;
            hit_q   <= hit_d;
            hv_q    <= hv_d;
        end
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                exp_q[i] <= '0;
            end
        end else if (cfg.cfg_we_i && (state_q != ST_ARMED)) begin
            exp_q[cfg.cfg_addr_i] <= cfg.cfg_data_i;
        end
    end

    assign busy_o    = (state_q == ST_ARMED);
    assign pass_o    = (state_q == ST_PASS);
    assign fail_o    = (state_q == ST_FAIL);
    assign timeout_o = to_q;
    assign step_o    = step_q;
    assign hit_o     = hit_q;
    assign hit_val_o = hv_q;
endmodule

// File: tb/tb_checkpoint_seq_monitor.sv
// Bench for checkpoint_seq_monitor: an in-order and a strict instance share one bus.
// Hits of the in-order instance are checked against a queue of expected values.
module tb_checkpoint_seq_monitor;
    localparam int DW = 16;
    localparam int DEPTH = 8;
    localparam int AW = 3;

    logic clk = 1'b0;
    logic rst;
    logic [DW-1:0] chk;

    always #5 clk = ~clk;

    checkpoint_seq_monitor_if #(.DATA_W(DW), .AW(AW)) cfg ();

    logic busy0, pass0, fail0, to0, hit0;
    logic [AW:0] step0;
    logic [DW-1:0] hv0;
    logic busy1, pass1, fail1, to1, hit1;
    logic [AW:0] step1;
    logic [DW-1:0] hv1;

    checkpoint_seq_monitor #(
        .DATA_W(DW), .DEPTH(DEPTH), .STABLE_CYC(2),
        .TIMEOUT(100), .TO_W(32), .MODE(0)
    ) dut0 (
        .wb_clk_i(clk), .wb_rst_i(rst), .chk_i(chk), .cfg(cfg.slave),
        .busy_o(busy0), .pass_o(pass0), .fail_o(fail0), .timeout_o(to0),
        .step_o(step0), .hit_o(hit0), .hit_val_o(hv0)
    );

    checkpoint_seq_monitor #(
        .DATA_W(DW), .DEPTH(DEPTH), .STABLE_CYC(2),
        .TIMEOUT(100), .TO_W(32), .MODE(1)
    ) dut1 (
        .wb_clk_i(clk), .wb_rst_i(rst), .chk_i(chk), .cfg(cfg.slave),
        .busy_o(busy1), .pass_o(pass1), .fail_o(fail1), .timeout_o(to1),
        .step_o(step1), .hit_o(hit1), .hit_val_o(hv1)
    );

    int checks = 0;
    int errors = 0;
    logic [DW-1:0] sbq [$];
    logic [DW-1:0] sb_exp;

    always @(posedge clk) begin
        #1;
        if (hit0 === 1'b1) begin
            checks++;
            if (sbq.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected_hit got %h want none", hv0);
            end else begin
                sb_exp = sbq.pop_front();
                if (hv0 !== sb_exp) begin
                    errors++;
                    $display("FAIL sb_hit_val got %h want %h", hv0, sb_exp);
                end
            end
        end
    end

    task automatic cfg_wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
        @(negedge clk);
        cfg.cfg_we_i = 1'b1;
        cfg.cfg_addr_i = a;
        cfg.cfg_data_i = d;
        @(negedge clk);
        cfg.cfg_we_i = 1'b0;
    endtask

    task automatic arm(input logic [AW:0] len);
        @(negedge clk);
        cfg.cfg_len_i = len;
        cfg.start_i = 1'b1;
        @(negedge clk);
        cfg.start_i = 1'b0;
    endtask

    task automatic abort_pulse();
        @(negedge clk);
        cfg.abort_i = 1'b1;
        @(negedge clk);
        cfg.abort_i = 1'b0;
    endtask

    task automatic hold(input logic [DW-1:0] v, input int n);
        @(negedge clk);
        chk = v;
        repeat (n - 1) @(negedge clk);
    endtask

    task automatic sb_drained(input string nm);
        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL %s_sb_left got %0d want 0", nm, sbq.size());
        end
        sbq.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        chk = '0;
        cfg.cfg_we_i = 1'b0;
        cfg.cfg_addr_i = '0;
        cfg.cfg_data_i = '0;
        cfg.cfg_len_i = '0;
        cfg.start_i = 1'b0;
        cfg.abort_i = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({busy0, pass0, fail0, to0, hit0, step0, hv0} !== '0) begin
            errors++;
            $display("FAIL reset_dut0 got %b%b%b%b%b %0d %h want all 0",
                     busy0, pass0, fail0, to0, hit0, step0, hv0);
        end
        checks++;
        if ({busy1, pass1, fail1, to1, hit1, step1, hv1} !== '0) begin
            errors++;
            $display("FAIL reset_dut1 got %b%b%b%b%b %0d %h want all 0",
                     busy1, pass1, fail1, to1, hit1, step1, hv1);
        end
    endtask

    logic [DW-1:0] prog [6] = '{16'hAB40, 16'h003E, 16'h0044,
                                16'h004A, 16'h0050, 16'hAB51};

    task automatic load_prog();
        for (int i = 0; i < 6; i++) cfg_wr(AW'(i), prog[i]);
    endtask

    task automatic test_sequence();
        load_prog();
        arm(4'd6);
        checks++;
        if (busy0 !== 1'b1) begin
            errors++;
            $display("FAIL seq_busy got %b want 1", busy0);
        end
        for (int i = 0; i < 6; i++) begin
            sbq.push_back(prog[i]);
            hold(prog[i], 4);
        end
        repeat (6) @(negedge clk);
        checks++;
        if ({pass0, fail0, busy0, step0, hv0} !== {3'b100, 4'd6, 16'hAB51}) begin
            errors++;
            $display("FAIL seq_end got p%b f%b b%b s%0d v%h want p1 f0 b0 s6 vAB51",
                     pass0, fail0, busy0, step0, hv0);
        end
        checks++;
        if ({pass1, step1} !== {1'b1, 4'd6}) begin
            errors++;
            $display("FAIL seq_strict got p%b s%0d want p1 s6", pass1, step1);
        end
        sb_drained("seq");
    endtask

    task automatic test_stray();
        arm(4'd6);
        for (int i = 0; i < 6; i++) begin
            sbq.push_back(prog[i]);
            hold(prog[i], 4);
            hold(16'h1234, 4);
        end
        checks++;
        if ({pass0, fail0, step0} !== {2'b10, 4'd6}) begin
            errors++;
            $display("FAIL stray_inorder got p%b f%b s%0d want p1 f0 s6",
                     pass0, fail0, step0);
        end
        checks++;
        if ({pass1, fail1, to1, step1} !== {3'b010, 4'd1}) begin
            errors++;
            $display("FAIL stray_strict got p%b f%b t%b s%0d want p0 f1 t0 s1",
                     pass1, fail1, to1, step1);
        end
        sb_drained("stray");
    endtask

    task automatic test_glitch();
        cfg_wr(3'd0, 16'h003E);
        arm(4'd1);
        @(negedge clk);
        chk = 16'h003E;
        @(negedge clk);
        chk = 16'h1234;
        repeat (8) @(negedge clk);
        checks++;
        if ({step0, busy0} !== {4'd0, 1'b1}) begin
            errors++;
            $display("FAIL glitch_nohit got s%0d b%b want s0 b1", step0, busy0);
        end
        @(negedge clk);
        chk = 16'h003E;
        sbq.push_back(16'h003E);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk = 16'h1234;
        @(posedge clk);
        #1;
        checks++;
        if (hit0 !== 1'b0) begin
            errors++;
            $display("FAIL glitch_early got %b want 0", hit0);
        end
        @(posedge clk);
        #1;
        checks++;
        if ({hit0, hv0} !== {1'b1, 16'h003E}) begin
            errors++;
            $display("FAIL glitch_latency got h%b v%h want h1 v003e", hit0, hv0);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (pass0 !== 1'b1) begin
            errors++;
            $display("FAIL glitch_pass got %b want 1", pass0);
        end
        sb_drained("glitch");
    endtask

    task automatic test_timeout();
        cfg_wr(3'd0, 16'h0050);
        cfg_wr(3'd1, 16'h0060);
        arm(4'd2);
        repeat (99) @(posedge clk);
        #1;
        checks++;
        if (fail0 !== 1'b0) begin
            errors++;
            $display("FAIL to_early got %b want 0", fail0);
        end
        @(posedge clk);
        #1;
        checks++;
        if ({fail0, to0, step0} !== {2'b11, 4'd0}) begin
            errors++;
            $display("FAIL to_fire got f%b t%b s%0d want f1 t1 s0", fail0, to0, step0);
        end
        arm(4'd2);
        repeat (95) @(negedge clk);
        chk = 16'h0050;
        sbq.push_back(16'h0050);
        repeat (5) @(posedge clk);
        #1;
        checks++;
        if ({hit0, fail0, step0} !== {2'b10, 4'd1}) begin
            errors++;
            $display("FAIL to_hit99 got h%b f%b s%0d want h1 f0 s1", hit0, fail0, step0);
        end
        repeat (99) @(posedge clk);
        #1;
        checks++;
        if (fail0 !== 1'b0) begin
            errors++;
            $display("FAIL to_restart_early got %b want 0", fail0);
        end
        @(posedge clk);
        #1;
        checks++;
        if ({fail0, to0, step0} !== {2'b11, 4'd1}) begin
            errors++;
            $display("FAIL to_restart got f%b t%b s%0d want f1 t1 s1", fail0, to0, step0);
        end
        sb_drained("timeout");
    endtask

    task automatic test_repeat();
        cfg_wr(3'd0, 16'h0044);
        cfg_wr(3'd1, 16'h0044);
        arm(4'd2);
        sbq.push_back(16'h0044);
        hold(16'h0044, 20);
        checks++;
        if ({step0, pass0} !== {4'd1, 1'b0}) begin
            errors++;
            $display("FAIL rep_once got s%0d p%b want s1 p0", step0, pass0);
        end
        hold(16'h0000, 4);
        sbq.push_back(16'h0044);
        hold(16'h0044, 6);
        checks++;
        if ({step0, pass0, fail0} !== {4'd2, 2'b10}) begin
            errors++;
            $display("FAIL rep_pass got s%0d p%b f%b want s2 p1 f0", step0, pass0, fail0);
        end
        sb_drained("repeat");
    endtask

    task automatic test_misc();
        arm(4'd0);
        checks++;
        if ({fail0, to0, busy0, pass0} !== 4'b1000) begin
            errors++;
            $display("FAIL len0 got f%b t%b b%b p%b want f1 t0 b0 p0",
                     fail0, to0, busy0, pass0);
        end
        arm(4'd9);
        checks++;
        if ({fail0, busy0} !== 2'b10) begin
            errors++;
            $display("FAIL len9 got f%b b%b want f1 b0", fail0, busy0);
        end
        cfg_wr(3'd0, 16'h0011);
        cfg_wr(3'd1, 16'h0022);
        cfg_wr(3'd2, 16'h0033);
        arm(4'd3);
        sbq.push_back(16'h0011);
        hold(16'h0011, 6);
        abort_pulse();
        checks++;
        if ({busy0, pass0, fail0, to0, step0} !== {4'b0000, 4'd1}) begin
            errors++;
            $display("FAIL abort got b%b p%b f%b t%b s%0d want b0 p0 f0 t0 s1",
                     busy0, pass0, fail0, to0, step0);
        end
        cfg_wr(3'd0, 16'h0055);
        arm(4'd1);
        cfg_wr(3'd0, 16'h0066);
        hold(16'h0066, 6);
        checks++;
        if ({step0, busy0} !== {4'd0, 1'b1}) begin
            errors++;
            $display("FAIL cfg_armed got s%0d b%b want s0 b1", step0, busy0);
        end
        sbq.push_back(16'h0055);
        hold(16'h0055, 6);
        checks++;
        if (pass0 !== 1'b1) begin
            errors++;
            $display("FAIL cfg_armed_pass got %b want 1", pass0);
        end
        cfg_wr(3'd0, 16'h0077);
        cfg_wr(3'd1, 16'h0088);
        arm(4'd2);
        sbq.push_back(16'h0077);
        hold(16'h0077, 6);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({busy0, pass0, fail0, to0, hit0, step0, hv0} !== '0) begin
            errors++;
            $display("FAIL mid_reset got b%b p%b f%b t%b h%b s%0d v%h want all 0",
                     busy0, pass0, fail0, to0, hit0, step0, hv0);
        end
        rst = 1'b0;
        arm(4'd1);
        sbq.push_back(16'h0000);
        hold(16'h0000, 6);
        checks++;
        if (pass0 !== 1'b1) begin
            errors++;
            $display("FAIL reset_lost_exp got %b want 1", pass0);
        end
        sb_drained("misc");
    endtask

    initial begin
        test_reset();
        test_sequence();
        test_stray();
        test_glitch();
        test_timeout();
        test_repeat();
        test_misc();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
